// File: rtl/fp16_add_arbiter_if.sv
// Requester, response and adder-side signals of the shared FP16 adder arbiter.
// slave: arbiter side; master: requesters / adder / environment side.
interface fp16_add_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDX_W-1:0]   rsp_id;
    logic [15:0]        rsp_sum;
    logic [3:0]         rsp_flags;
    logic               rsp_err;
    logic               add_start;
    logic [15:0]        add_a;
    logic [15:0]        add_b;
    logic [15:0]        add_sum;
    logic               add_n;
    logic               add_v;
    logic               add_u;
    logic               add_z;
    logic               add_ready;
    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  add_sum, add_n, add_v, add_u, add_z, add_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags, rsp_err,
        output add_start, add_a, add_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output add_sum, add_n, add_v, add_u, add_z, add_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags, rsp_err,
        input  add_start, add_a, add_b, busy
    );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one sequential FP16 adder among NREQ requesters, one op in flight.
// Optional FP16_ARB_TIMEOUT_EN: abort BUSY after TIMEOUT cycles without add_ready (qNaN, rsp_err=1).
module fp16_add_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    fp16_add_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             gnt_found;
    logic             take;
    logic             tmo;

    // Search starts one past the last grant so a held request is served within NREQ grants.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign take = rst_n && (state == IDLE) && bus.add_ready && gnt_found;

    always_comb begin
        bus.req_ready = '0;
        if (take) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (bus.add_ready || tmo) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.add_start = (state == ISSUE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= IDX_W'(NREQ - 1);
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_flags <= '0;
        end else begin
            if (take) begin
                ptr        <= gnt_idx;
                bus.add_a  <= bus.req_a[16*gnt_idx +: 16];
                bus.add_b  <= bus.req_b[16*gnt_idx +: 16];
                bus.rsp_id <= gnt_idx;
            end
            if (state == BUSY) begin
                if (bus.add_ready) begin
                    bus.rsp_sum   <= bus.add_sum;
                    bus.rsp_flags <= {bus.add_n, bus.add_v, bus.add_u, bus.add_z};
                end else if (tmo) begin
                    bus.rsp_sum   <= 16'h7E00;
                    bus.rsp_flags <= '0;
                end
            end
        end
    end

`ifdef FP16_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == BUSY && (bus.add_ready || tmo)) begin
                err_q <= !bus.add_ready;
            end
        end
    end

    assign tmo         = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign bus.rsp_err = err_q;
`else
    assign tmo         = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Self-checking bench for fp16_add_arbiter: transaction-level model plus directed and random stimulus.
// Honours FP16_ARB_TIMEOUT_EN the same way the design does.
module tb_fp16_add_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
`ifdef FP16_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int W_GRANT = 0;
    localparam int W_START = 1;
    localparam int W_RSP   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp16_add_arbiter_if #(.NREQ(NREQ)) bus();

    fp16_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external adder: exact for the FP16 cases pinned below, a fixed hash otherwise.
    function automatic logic [19:0] fake_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        if (a == 16'h3C00 && b == 16'h3C00)                s = 16'h4000;
        else if (a[14:0] == b[14:0] && a[15] != b[15])     s = 16'h0000;
        else                                               s = a ^ {b[7:0], b[15:8]} ^ 16'h5A3C;
        return {s[15], s[3] ^ s[9], s[5], (s == 16'h0000), s};
    endfunction

    int unsigned add_cnt    = 0;
    logic [19:0] add_res    = '0;
    int unsigned adder_lat  = 3;
    bit          adder_hang = 1'b0;

    always @(posedge clk) begin
        if (add_cnt != 0) begin
            if (!adder_hang) add_cnt <= add_cnt - 1;
        end else if (bus.add_start === 1'b1) begin
            add_cnt <= adder_lat;
            add_res <= fake_add(bus.add_a, bus.add_b);
        end
    end

    assign bus.add_ready = (add_cnt == 0);
    assign bus.add_sum   = bus.add_ready ? add_res[15:0] : 16'hDEAD;
    assign {bus.add_n, bus.add_v, bus.add_u, bus.add_z} = bus.add_ready ? add_res[19:16] : 4'b1111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_sig(input int which, input int limit, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < limit && !ok; t++) begin
            @(negedge clk);
            case (which)
                W_GRANT: ok = (bus.req_ready != '0);
                W_START: ok = (bus.add_start === 1'b1);
                default: ok = (bus.rsp_valid === 1'b1);
            endcase
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: event not seen, required within %0d cycles (cycle %0d)", name, limit, cyc);
        end
    endtask

    // Transaction model: one op moves granted -> started -> done -> consumed.
    initial begin : model
        bit               act, started, done, err;
        int               id, ptr, wt, g, best, d;
        logic [15:0]      ma, mb, sum;
        logic [3:0]       fl;
        logic [NREQ-1:0]  exp_rdy;
        act = 0; started = 0; done = 0; err = 0; id = 0; ptr = NREQ - 1; wt = 0;
        ma = '0; mb = '0; sum = '0; fl = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                act = 0; started = 0; done = 0; ptr = NREQ - 1; ma = '0; mb = '0;
                chk("rst_req_ready", bus.req_ready, '0);
                chk("rst_rsp_valid", bus.rsp_valid, '0);
                chk("rst_busy", bus.busy, '0);
                chk("rst_add_start", bus.add_start, '0);
                chk("rst_add_a", bus.add_a, '0);
                chk("rst_add_b", bus.add_b, '0);
                chk("rst_rsp_id", bus.rsp_id, '0);
                chk("rst_rsp_sum", bus.rsp_sum, '0);
                chk("rst_rsp_flags", bus.rsp_flags, '0);
                chk("rst_rsp_err", bus.rsp_err, '0);
                continue;
            end
            g = -1;
            best = NREQ;
            if (!act && bus.add_ready) begin
                for (int j = 0; j < NREQ; j++) begin
                    d = (j + NREQ - ptr - 1) % NREQ;
                    if (bus.req_valid[j] && d < best) begin
                        best = d;
                        g = j;
                    end
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", bus.busy, act);
            chk("add_start", bus.add_start, act && !started);
            chk("rsp_valid", bus.rsp_valid, act && done);
            chk("add_a", bus.add_a, ma);
            chk("add_b", bus.add_b, mb);
            if (act && done) begin
                chk("rsp_id", bus.rsp_id, id);
                chk("rsp_sum", bus.rsp_sum, sum);
                chk("rsp_flags", bus.rsp_flags, fl);
                chk("rsp_err", bus.rsp_err, err);
            end
            if (!act) begin
                if (g >= 0) begin
                    act = 1; started = 0; done = 0; id = g; ptr = g;
                    ma = bus.req_a[16*g +: 16];
                    mb = bus.req_b[16*g +: 16];
                end
            end else if (!started) begin
                started = 1;
                wt = 0;
            end else if (!done) begin
                if (bus.add_ready) begin
                    {fl, sum} = fake_add(ma, mb);
                    err = 0;
                    done = 1;
                end else if (TMO_EN && wt == TIMEOUT - 1) begin
                    sum = 16'h7E00; fl = '0; err = 1; done = 1;
                end else begin
                    wt++;
                end
            end else if (bus.rsp_ready) begin
                act = 0; done = 0; started = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (15) step();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    initial begin : stim
        int c0, gc, s;
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        #1;
        do_reset();

        // Single op 1.0 + 1.0 from requester 2.
        bus.req_a[32 +: 16] = 16'h3C00;
        bus.req_b[32 +: 16] = 16'h3C00;
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        wait_sig(W_GRANT, 5, "t1_grant_seen");
        c0 = cyc;
        chk("t1_grant", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        wait_sig(W_START, 5, "t1_start_seen");
        chk("t1_start_cycle", cyc - c0, 1);
        wait_sig(W_RSP, 20, "t1_rsp_seen");
        chk("t1_rsp_cycle", cyc - c0, 6);
        chk("t1_rsp_id", bus.rsp_id, 2);
        chk("t1_rsp_sum", bus.rsp_sum, 16'h4000);
        drain();

        // All requesters held from reset: round-robin 0,1,2,3,0 at one op per 7 cycles.
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        do_reset();
        gc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_sig(W_GRANT, 20, "t2_grant_seen");
            chk("t2_grant_order", bus.req_ready, 4'b0001 << (k % 4));
            if (k > 0) chk("t2_throughput", cyc - gc, 7);
            gc = cyc;
            wait_sig(W_RSP, 20, "t2_rsp_seen");
            chk("t2_rsp_id", bus.rsp_id, k % 4);
        end
        step();
        drain();

        // Back-pressure for 10 RESP cycles, then release.
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b0;
        wait_sig(W_GRANT, 20, "t3_grant_seen");
        chk("t3_grant", bus.req_ready, 4'b1000);
        step();
        wait_sig(W_RSP, 20, "t3_rsp_seen");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("t3_hold_req_ready", bus.req_ready, '0);
            chk("t3_hold_rsp_valid", bus.rsp_valid, 1'b1);
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_handshake_no_grant", bus.req_ready, '0);
        @(negedge clk);
        chk("t3_idle_next", bus.busy, 1'b0);
        chk("t3_regrant_next", bus.req_ready, 4'b1000);
        step();
        drain();

        // Reset while the adder is mid-operation.
        adder_lat = 10;
        bus.req_valid = 4'b0001;
        wait_sig(W_START, 20, "t4_start_seen");
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", bus.busy, 1'b0);
        chk("t4_rst_req_ready", bus.req_ready, '0);
        chk("t4_rst_add_a", bus.add_a, '0);
        chk("t4_rst_add_ready_low", bus.add_ready, 1'b0);
        step();
        rst_n = 1'b1;
        adder_lat = 3;
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (bus.add_ready) begin
                    chk("t4_grant_after_ready", bus.req_ready, 4'b0001);
                    seen = 1'b1;
                end else begin
                    chk("t4_no_grant_while_adder_busy", bus.req_ready, '0);
                end
            end
            chk("t4_adder_ready_seen", seen, 1'b1);
        end
        step();
        drain();

        // Adder that never raises ready.
        bus.req_a[16 +: 16] = 16'h1234;
        bus.req_b[16 +: 16] = 16'h4321;
        adder_hang = 1'b1;
        bus.req_valid = 4'b0010;
        wait_sig(W_GRANT, 20, "t5_grant_seen");
        step();
        bus.req_valid = '0;
        wait_sig(W_START, 5, "t5_start_seen");
        s = cyc;
`ifdef FP16_ARB_TIMEOUT_EN
        wait_sig(W_RSP, 40, "t5_timeout_rsp_seen");
        chk("t5_timeout_cycle", cyc - s, TIMEOUT + 1);
        chk("t5_rsp_err", bus.rsp_err, 1'b1);
        chk("t5_rsp_sum_qnan", bus.rsp_sum, 16'h7E00);
        chk("t5_rsp_flags", bus.rsp_flags, 4'b0000);
        adder_hang = 1'b0;
`else
        repeat (30) @(negedge clk);
        chk("t5_still_busy", bus.busy, 1'b1);
        chk("t5_no_rsp", bus.rsp_valid, 1'b0);
        adder_hang = 1'b0;
        wait_sig(W_RSP, 20, "t5_rsp_after_release");
        chk("t5_rsp_err", bus.rsp_err, 1'b0);
`endif
        step();
        drain();

        // 1.0 + -1.0: zero flag passes through.
        bus.req_a[32 +: 16] = 16'h3C00;
        bus.req_b[32 +: 16] = 16'hBC00;
        bus.req_valid = 4'b0100;
        wait_sig(W_GRANT, 20, "t6_grant_seen");
        step();
        bus.req_valid = '0;
        wait_sig(W_RSP, 20, "t6_rsp_seen");
        chk("t6_rsp_sum", bus.rsp_sum, 16'h0000);
        chk("t6_rsp_flags_z", bus.rsp_flags, 4'b0001);
        step();
        drain();

        // Random traffic, back-pressure and adder latency.
        for (int n = 0; n < 1500; n++) begin
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_a[16*i +: 16] = 16'($urandom);
                bus.req_b[16*i +: 16] = 16'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            adder_lat = $urandom_range(1, 5);
            step();
        end
        adder_lat = 3;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
